sha256_host_bridge: RTL
=======================

Name: sha256_host_bridge

Overview:
- Memory-side responder and host sequencer for the simplified SHA-256 engine.
- Owns a word-addressed RAM and answers the engine's memory bus (registered reads, engine writes).
- On the host side it accepts a message as a valid/ready word stream, writes it into RAM, then pulses the engine start.
- After the engine finishes, it reads the 8-word digest back out of RAM and streams it to the host.

Parameters:
NUM_OF_WORDS, 20, message length in 32-bit words; must match the engine's value.
DEPTH, 256, RAM depth in words.
MSG_BASE, 16'h0000, word address of message word 0; driven on message_addr.
OUT_BASE, 16'h00C0, word address of digest word 0; driven on output_addr. Legal only if OUT_BASE+9 <= DEPTH and the message and digest ranges do not overlap.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  host message word valid
in_ready  out  1  bridge accepts in_data
in_data  in  32  message word
out_valid  out  1  digest word valid
out_ready  in  1  host accepts out_data
out_data  out  32  digest word, h0 first
out_last  out  1  high with digest word 7
busy  out  1  high in every state except IDLE
eng_start  out  1  one-cycle start pulse to the engine
eng_done  in  1  engine done (high when the engine is idle)
message_addr  out  16  constant MSG_BASE
output_addr  out  16  constant OUT_BASE
eng_mem_we  in  1  engine write enable
eng_mem_addr  in  16  engine word address
eng_mem_write_data  in  32  engine write data
eng_mem_read_data  out  32  registered read data to the engine

Behaviour:
- Reset: reset_n, asynchronous, active-low; clock clk.
  - Reset goes to IDLE with in_ready=0, out_valid=0, out_last=0, busy=0, eng_start=0, eng_mem_read_data=0, word counter=0.
  - RAM contents are not reset.
  - Reset mid-operation aborts immediately; no partial digest is emitted.
- Engine port:
  - Every posedge, eng_mem_read_data <= RAM[eng_mem_addr]. This gives 1-cycle read latency: data for an address held during cycle N is valid during cycle N+1.
  - Reads with eng_mem_addr >= DEPTH return 0.
  - Engine writes commit at posedge only when eng_mem_we=1, state==WAIT_DONE, eng_done=0 and eng_mem_addr < DEPTH. All other engine writes are dropped.
  - This gating is required: the engine leaves we asserted in idle and writes one extra word (OUT_BASE+8) on its return to idle.
- FSM states: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, RD_REQ, RD_WAIT, OUT.
  - IDLE: the next cycle goes to LOAD with counter=0.
  - LOAD: in_ready=1. Each in_valid&in_ready cycle writes RAM[MSG_BASE+counter] <= in_data and increments counter. When word NUM_OF_WORDS-1 is accepted, go to START. in_ready is 0 outside LOAD.
  - START: eng_start=1 for exactly one cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: wait for eng_done=0, then go to WAIT_DONE. There is no timeout.
  - WAIT_DONE: wait for eng_done=1, then counter=0 and go to RD_REQ.
  - RD_REQ: host-side RAM read at OUT_BASE+counter, then go to RD_WAIT.
  - RD_WAIT: capture the read word into out_data and go to OUT.
  - OUT: out_valid=1; out_data and out_last are held stable until out_ready.
    - On handshake with counter==7, go to IDLE.
    - Otherwise increment counter and go to RD_REQ.
  - out_last=1 only when counter==7 in OUT.
- Host and engine RAM accesses are never active in the same state, so there is no arbitration.
- Address arithmetic is 16-bit and unsigned; host addresses never wrap because the parameter constraints guarantee this.
- Simultaneous events:
  - in_valid high in any state other than LOAD is ignored.
  - out_ready high while out_valid=0 has no effect.
  - eng_done glitches in LOAD/START are ignored.

Decomposition:
- Package sha256_bridge_pkg holds:
  - the FSM state enum;
  - DIGEST_WORDS=8;
  - the default MSG_BASE and OUT_BASE.
- One sub-module: sha256_bridge_ram.
  - Port A (engine): registered read plus gated write.
  - Port B (host): write, and 1-cycle registered read.
  - DEPTH x 32.

Test Plan:
- Real engine, NUM_OF_WORDS=1, stream 32'h61626364 -> out words 88d4266f, d4e6338d, 13b845fc, f289579d, 209c8978, 23b9217d, a3e16193, 6f031589; out_last only on word 7; busy returns to 0.
- Engine stub, NUM_OF_WORDS=20, in_valid toggled every other cycle -> exactly 20 writes at addr 0..19, then a single one-cycle eng_start pulse.
- Stub holds eng_done=1 for 50 cycles after start -> bridge stays in WAIT_BUSY; no output and no engine writes accepted; proceeds once done drops and rises.
- Stub writes 0xDEADBEEF to addr OUT_BASE in IDLE, then writes digest 0..7 in WAIT_DONE -> streamed digest equals the WAIT_DONE data, not 0xDEADBEEF.
- Backpressure: out_ready low for 10 cycles on word 3 -> out_data and out_valid stable; all 8 words delivered in order.
- Assert reset_n mid-OUT (word 4) -> outputs go to reset values asynchronously; after release, a new LOAD and digest completes correctly.

Source files
------------

// File: rtl/sha256_bridge_pkg.sv
// Shared types and defaults for the SHA-256 host bridge: FSM states, digest size,
// default message/digest base addresses.
package sha256_bridge_pkg;

  localparam int          DIGEST_WORDS     = 8;
  localparam logic [15:0] DEFAULT_MSG_BASE = 16'h0000;
  localparam logic [15:0] DEFAULT_OUT_BASE = 16'h00C0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_OUT
  } bridge_state_t;

endpackage

// File: rtl/sha256_host_bridge_if.sv
// Host-side valid/ready streams: message words in, digest words out.
interface sha256_host_bridge_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/sha256_bridge_ram.sv
// DEPTH x 32 word RAM: port A serves the engine (range-checked), port B the host sequencer.
module sha256_bridge_ram
  import sha256_bridge_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          a_we,
  input  logic [15:0]   a_addr,
  input  logic [31:0]   a_wdata,
  output logic [31:0]   a_rdata,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [31:0]   b_wdata,
  output logic [31:0]   b_rdata
);

  logic [31:0] mem [DEPTH];
  logic        a_in_range;

  assign a_in_range = 32'(a_addr) < 32'(DEPTH);

  always_ff @(posedge clk) begin
    if (a_we && a_in_range) mem[a_addr[AW-1:0]] <= a_wdata;
    if (b_we)               mem[b_addr]         <= b_wdata;
  end

  // Read registers reset so the engine sees 0 after reset; the array itself is not reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      a_rdata <= a_in_range ? mem[a_addr[AW-1:0]] : '0;
      b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/sha256_host_bridge.sv
// Host sequencer for the SHA-256 engine: loads a message into RAM, starts the engine,
// then streams the 8-word digest back to the host. Also answers the engine memory bus.
module sha256_host_bridge
  import sha256_bridge_pkg::*;
#(
  parameter int          NUM_OF_WORDS = 20,
  parameter int          DEPTH        = 256,
  parameter logic [15:0] MSG_BASE     = DEFAULT_MSG_BASE,
  parameter logic [15:0] OUT_BASE     = DEFAULT_OUT_BASE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sha256_host_bridge_if.slave   host,
  output logic                  busy,
  output logic                  eng_start,
  input  logic                  eng_done,
  output logic [15:0]           message_addr,
  output logic [15:0]           output_addr,
  input  logic                  eng_mem_we,
  input  logic [15:0]           eng_mem_addr,
  input  logic [31:0]           eng_mem_write_data,
  output logic [31:0]           eng_mem_read_data
);

  localparam int              AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [15:0]     LAST_MSG   = 16'(NUM_OF_WORDS - 1);
  localparam logic [15:0]     LAST_DIG   = 16'(DIGEST_WORDS - 1);
  localparam logic [AW-1:0]   MSG_BASE_A = AW'(MSG_BASE);
  localparam logic [AW-1:0]   OUT_BASE_A = AW'(OUT_BASE);

  bridge_state_t state;
  logic [15:0]   cnt;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_rdata;
  logic          eng_we_ok;

  assign message_addr = MSG_BASE;
  assign output_addr  = OUT_BASE;

  // The engine keeps we high while idle and writes a stray word on its way back,
  // so only writes made while it is actually running are allowed through.
  always_comb begin
    host_we   = (state == ST_LOAD) && host.in_valid && host.in_ready;
    host_addr = (state == ST_LOAD) ? MSG_BASE_A + cnt[AW-1:0]
                                   : OUT_BASE_A + cnt[AW-1:0];
    eng_we_ok = eng_mem_we && (state == ST_WAIT_DONE) && !eng_done;
  end

  sha256_bridge_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .a_we    (eng_we_ok),
    .a_addr  (eng_mem_addr),
    .a_wdata (eng_mem_write_data),
    .a_rdata (eng_mem_read_data),
    .b_we    (host_we),
    .b_addr  (host_addr),
    .b_wdata (host.in_data),
    .b_rdata (host_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      busy           <= 1'b0;
      eng_start      <= 1'b0;
      host.in_ready  <= 1'b0;
      host.out_valid <= 1'b0;
      host.out_last  <= 1'b0;
      host.out_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state         <= ST_LOAD;
          cnt           <= '0;
          busy          <= 1'b1;
          host.in_ready <= 1'b1;
        end
        ST_LOAD: begin
          if (host.in_valid) begin
            cnt <= cnt + 16'd1;
            if (cnt == LAST_MSG) begin
              state         <= ST_START;
              host.in_ready <= 1'b0;
              eng_start     <= 1'b1;
            end
          end
        end
        ST_START: begin
          eng_start <= 1'b0;
          state     <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (!eng_done) state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (eng_done) begin
            cnt   <= '0;
            state <= ST_RD_REQ;
          end
        end
        ST_RD_REQ: begin
          state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          host.out_data  <= host_rdata;
          host.out_valid <= 1'b1;
          host.out_last  <= (cnt == LAST_DIG);
          state          <= ST_OUT;
        end
        ST_OUT: begin
          if (host.out_ready) begin
            host.out_valid <= 1'b0;
            host.out_last  <= 1'b0;
            if (cnt == LAST_DIG) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              cnt   <= cnt + 16'd1;
              state <= ST_RD_REQ;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
